// File: rtl/shift_reg_pkg.sv
// Shared types for the shift register sequencer: FSM state encoding and
// shift-direction constants.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_down_counter.sv
// Loadable down-counter tracking the shifts still to go; is_one flags the
// final shift so the sequencer can leave SHIFT on that edge.
module shift_down_counter #(
    parameter int CNT_W = 5
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             is_one
);

    logic [CNT_W-1:0] value;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && (value != '0)) begin
            value <= value - 1'b1;
        end
    end

    assign is_one = (value == CNT_W'(1));

endmodule

// File: rtl/shift_reg_seq.sv
// Parallel-load shift register with a built-in "shift N times" sequencer.
// Define SHIFT_REG_SEQ_ROTATE_EN to add the Rotate input (recirculating shift).
module shift_reg_seq
    import shift_reg_pkg::*;
#(
    parameter  int WIDTH = 17,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             Start,
    input  logic [CNT_W-1:0] Count,
    input  logic             Dir,
    input  logic             Shift_In,
`ifdef SHIFT_REG_SEQ_ROTATE_EN
    input  logic             Rotate,
`endif
    output logic [WIDTH-1:0] Data_Out,
    output logic             Shift_Out,
    output logic             Busy,
    output logic             Done
);

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

    state_t           state;
    logic             dir_q;
    logic             bit_in;
    logic [WIDTH-1:0] shifted;
    logic             start_ok;
    logic [CNT_W-1:0] cnt_clamped;
    logic             cnt_is_one;

    // Start only counts in IDLE and loses to Load on the same edge.
    assign start_ok    = (state == IDLE) && Start && !Load;
    assign cnt_clamped = (Count > WIDTH_C) ? WIDTH_C : Count;

    assign Shift_Out = (dir_q == DIR_RIGHT) ? Data_Out[0] : Data_Out[WIDTH-1];

`ifdef SHIFT_REG_SEQ_ROTATE_EN
    logic rot_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rot_q <= 1'b0;
        end else if (start_ok) begin
            rot_q <= Rotate;
        end
    end

    assign bit_in = rot_q ? Shift_Out : Shift_In;
`else
    assign bit_in = Shift_In;
`endif

    assign shifted = (dir_q == DIR_RIGHT) ? {bit_in, Data_Out[WIDTH-1:1]}
                                          : {Data_Out[WIDTH-2:0], bit_in};

    shift_down_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .load     (start_ok),
        .load_val (cnt_clamped),
        .dec      (state == SHIFT),
        .is_one   (cnt_is_one)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            Data_Out <= '0;
            dir_q    <= DIR_LEFT;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Load) begin
                        Data_Out <= D;
                    end else if (Start) begin
                        dir_q <= Dir;
                        if (Count == '0) begin
                            state <= DONE;
                            Done  <= 1'b1;
                        end else begin
                            state <= SHIFT;
                            Busy  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    Data_Out <= shifted;
                    if (cnt_is_one) begin
                        state <= DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed bench for shift_reg_seq at WIDTH=8 with hand-computed expectations.
module tb_shift_reg_seq;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             Clk = 1'b0;
    logic             Reset_n;
    logic             Load;
    logic [WIDTH-1:0] D;
    logic             Start;
    logic [CNT_W-1:0] Count;
    logic             Dir;
    logic             Shift_In;
`ifdef SHIFT_REG_SEQ_ROTATE_EN
    logic             Rotate;
`endif
    logic [WIDTH-1:0] Data_Out;
    logic             Shift_Out;
    logic             Busy;
    logic             Done;

    int n_assert = 0;
    int n_fail   = 0;

    shift_reg_seq #(.WIDTH(WIDTH)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Load      (Load),
        .D         (D),
        .Start     (Start),
        .Count     (Count),
        .Dir       (Dir),
        .Shift_In  (Shift_In),
`ifdef SHIFT_REG_SEQ_ROTATE_EN
        .Rotate    (Rotate),
`endif
        .Data_Out  (Data_Out),
        .Shift_Out (Shift_Out),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    int cyc;
    int busy_cyc;
    logic seen_done;

    initial begin
        Reset_n = 1'b0; Load = 1'b0; D = '0; Start = 1'b0; Count = '0;
        Dir = 1'b0; Shift_In = 1'b0;
`ifdef SHIFT_REG_SEQ_ROTATE_EN
        Rotate = 1'b0;
`endif
        #3;
        chk("rst_data", 32'(Data_Out), 32'h00);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_sout", 32'(Shift_Out), 32'd0);
        @(negedge Clk); @(negedge Clk);
        Reset_n = 1'b1;

        // Load then shift left 3 with Shift_In=1
        step(); Load = 1'b1; D = 8'hA5;
        step(); Load = 1'b0;
        chk("load_a5", 32'(Data_Out), 32'hA5);
        Start = 1'b1; Count = 4'd3; Dir = 1'b0; Shift_In = 1'b1;
        step(); Start = 1'b0;
        chk("l3_busy0", 32'(Busy), 32'd1);
        chk("l3_sout", 32'(Shift_Out), 32'd1);
        step();
        chk("l3_d1", 32'(Data_Out), 32'h4B);
        chk("l3_busy1", 32'(Busy), 32'd1);
        step();
        chk("l3_d2", 32'(Data_Out), 32'h97);
        chk("l3_busy2", 32'(Busy), 32'd1);
        chk("l3_nodone", 32'(Done), 32'd0);
        step();
        chk("l3_d3", 32'(Data_Out), 32'h2F);
        chk("l3_busy_off", 32'(Busy), 32'd0);
        chk("l3_done", 32'(Done), 32'd1);
        // Load/Start during DONE are ignored
        Load = 1'b1; Start = 1'b1; D = 8'h00;
        step(); Load = 1'b0; Start = 1'b0;
        chk("done_ign_data", 32'(Data_Out), 32'h2F);
        chk("done_ign_busy", 32'(Busy), 32'd0);
        chk("done_pulse_end", 32'(Done), 32'd0);

        // Right shift 2, Dir flipped mid-sequence has no effect
        Load = 1'b1; D = 8'h81;
        step(); Load = 1'b0;
        Start = 1'b1; Count = 4'd2; Dir = 1'b1; Shift_In = 1'b0;
        step(); Start = 1'b0; Dir = 1'b0;
        chk("r2_sout0", 32'(Shift_Out), 32'd1);
        step();
        chk("r2_d1", 32'(Data_Out), 32'h40);
        chk("r2_sout1", 32'(Shift_Out), 32'd0);
        step();
        chk("r2_d2", 32'(Data_Out), 32'h20);
        chk("r2_done", 32'(Done), 32'd1);
        step();

        // Count clamp: 12 -> 8 shifts
        Load = 1'b1; D = 8'hFF;
        step(); Load = 1'b0;
        Start = 1'b1; Count = 4'd12; Dir = 1'b0; Shift_In = 1'b0;
        step(); Start = 1'b0;
        cyc = 1; busy_cyc = Busy ? 1 : 0;
        while (!Done && cyc < 20) begin
            step();
            cyc++;
            if (Busy) busy_cyc++;
        end
        chk("clamp_done_cyc", 32'(cyc), 32'd9);
        chk("clamp_busy_cyc", 32'(busy_cyc), 32'd8);
        chk("clamp_data", 32'(Data_Out), 32'h00);
        step();

        // Count = 0: immediate Done, no shift
        Load = 1'b1; D = 8'h3C;
        step(); Load = 1'b0;
        Start = 1'b1; Count = 4'd0; Shift_In = 1'b1;
        step(); Start = 1'b0;
        chk("c0_done", 32'(Done), 32'd1);
        chk("c0_busy", 32'(Busy), 32'd0);
        chk("c0_data", 32'(Data_Out), 32'h3C);
        step();
        chk("c0_done_end", 32'(Done), 32'd0);

        // Load and Start together: load wins
        Load = 1'b1; Start = 1'b1; D = 8'h5A; Count = 4'd3; Shift_In = 1'b0;
        step(); Load = 1'b0; Start = 1'b0;
        chk("ls_data", 32'(Data_Out), 32'h5A);
        chk("ls_busy", 32'(Busy), 32'd0);
        step();
        chk("ls_busy2", 32'(Busy), 32'd0);

        // Load during SHIFT is ignored
        Start = 1'b1; Count = 4'd2; Dir = 1'b0;
        step(); Start = 1'b0;
        Load = 1'b1; D = 8'h00;
        step();
        chk("lsh_d1", 32'(Data_Out), 32'hB4);
        step(); Load = 1'b0;
        chk("lsh_d2", 32'(Data_Out), 32'h68);
        chk("lsh_done", 32'(Done), 32'd1);
        step();

        // Reset mid-sequence aborts with no Done
        Start = 1'b1; Count = 4'd4; Dir = 1'b0; Shift_In = 1'b1;
        step(); Start = 1'b0;
        step();
        #2 Reset_n = 1'b0;
        #1;
        chk("rmid_data", 32'(Data_Out), 32'h00);
        chk("rmid_busy", 32'(Busy), 32'd0);
        @(negedge Clk); @(negedge Clk);
        Reset_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (Done) seen_done = 1'b1;
        end
        chk("rmid_nodone", 32'(seen_done), 32'd0);
        chk("rmid_idle", 32'(Busy), 32'd0);
        chk("rmid_data2", 32'(Data_Out), 32'h00);

`ifdef SHIFT_REG_SEQ_ROTATE_EN
        Load = 1'b1; D = 8'h81;
        step(); Load = 1'b0;
        Start = 1'b1; Count = 4'd1; Dir = 1'b0; Rotate = 1'b1; Shift_In = 1'b0;
        step(); Start = 1'b0; Rotate = 1'b0;
        step();
        chk("rot_data", 32'(Data_Out), 32'h03);
        chk("rot_done", 32'(Done), 32'd1);
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
